// File: rtl/fast_nms_stream.sv
// FAST corner post-processing: optional 3x3 non-maximum suppression over a raster
// score stream, min-score filter, output FIFO and per-frame corner / drop statistics.
module fast_nms_stream #(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int SCORE_WIDTH = 13,
  parameter int FIFO_DEPTH  = 16,
  parameter int NMS_EN      = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ce,
  input  logic                   i_in_vld,
  input  logic                   i_in_corner,
  input  logic [SCORE_WIDTH-1:0] i_in_score,
  input  logic [9:0]             i_in_x,
  input  logic [9:0]             i_in_y,
  input  logic [SCORE_WIDTH-1:0] i_min_score,
  output logic                   o_out_vld,
  input  logic                   i_out_rdy,
  output logic [9:0]             o_out_x,
  output logic [9:0]             o_out_y,
  output logic [SCORE_WIDTH-1:0] o_out_score,
  output logic                   o_frame_done,
  output logic [15:0]            o_frame_corners,
  output logic                   o_overflow,
  output logic [15:0]            o_drop_cnt
);

  localparam int SW = SCORE_WIDTH;
  localparam int AW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 20 + SW;
  localparam logic [9:0]  X_LAST  = 10'(COL_NUM - 1);
  localparam logic [9:0]  Y_LAST  = 10'(ROW_NUM - 1);
  localparam logic [9:0]  X_BMAX  = 10'(COL_NUM - 2);
  localparam logic [9:0]  Y_BMAX  = 10'(ROW_NUM - 2);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Push stage: one candidate decision per accepted beat, shared by both modes.
  logic          r_p_vld;
  logic          r_p_keep;
  logic          r_p_last;
  logic [9:0]    r_p_x;
  logic [9:0]    r_p_y;
  logic [SW-1:0] r_p_score;

  generate
    if (NMS_EN != 0) begin : g_nms
      logic [SW-1:0] r_lb1 [COL_NUM];
      logic [SW-1:0] r_lb2 [COL_NUM];
      logic [SW-1:0] r_win [3][3];
      logic          r_s1_vld;
      logic [9:0]    r_s1_x;
      logic [9:0]    r_s1_y;
      logic [AW-1:0] w_addr;
      logic          w_beat;
      logic [SW-1:0] w_eff;
      logic [SW-1:0] w_c;
      logic          w_range;
      logic          w_keep;

      assign w_addr = i_in_x[AW-1:0];
      assign w_beat = i_ce & i_in_vld;
      assign w_eff  = i_in_corner ? i_in_score : '0;

      always_ff @(posedge i_clk) begin
        if (w_beat) begin
          r_lb2[w_addr] <= r_lb1[w_addr];
          r_lb1[w_addr] <= w_eff;
        end
      end

      // Window rows: 0 = y-2, 1 = y-1, 2 = y; columns: 0 = x-2 .. 2 = x.
      assign w_c     = r_win[1][1];
      assign w_range = (r_s1_x >= 10'd2) && (r_s1_x <= X_LAST) &&
                       (r_s1_y >= 10'd2) && (r_s1_y <= Y_LAST);
      // Strict against raster-earlier neighbours, >= against later: earliest tie wins.
      assign w_keep  = r_s1_vld && w_range && (w_c != '0) && (w_c >= i_min_score) &&
                       (w_c >  r_win[0][0]) && (w_c >  r_win[0][1]) &&
                       (w_c >  r_win[0][2]) && (w_c >  r_win[1][0]) &&
                       (w_c >= r_win[1][2]) && (w_c >= r_win[2][0]) &&
                       (w_c >= r_win[2][1]) && (w_c >= r_win[2][2]);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              r_win[r][c] <= '0;
          r_s1_vld  <= 1'b0;
          r_s1_x    <= '0;
          r_s1_y    <= '0;
          r_p_vld   <= 1'b0;
          r_p_keep  <= 1'b0;
          r_p_last  <= 1'b0;
          r_p_x     <= '0;
          r_p_y     <= '0;
          r_p_score <= '0;
        end else if (i_ce) begin
          if (i_in_vld) begin
            for (int r = 0; r < 3; r++) begin
              r_win[r][0] <= r_win[r][1];
              r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= r_lb2[w_addr];
            r_win[1][2] <= r_lb1[w_addr];
            r_win[2][2] <= w_eff;
            r_s1_x      <= i_in_x;
            r_s1_y      <= i_in_y;
          end
          r_s1_vld  <= i_in_vld;
          r_p_vld   <= r_s1_vld;
          r_p_keep  <= w_keep;
          r_p_last  <= r_s1_vld && (r_s1_x == X_LAST) && (r_s1_y == Y_LAST);
          r_p_x     <= r_s1_x - 10'd1;
          r_p_y     <= r_s1_y - 10'd1;
          r_p_score <= w_c;
        end
      end
    end else begin : g_byp
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_p_vld   <= 1'b0;
          r_p_keep  <= 1'b0;
          r_p_last  <= 1'b0;
          r_p_x     <= '0;
          r_p_y     <= '0;
          r_p_score <= '0;
        end else if (i_ce) begin
          r_p_vld   <= i_in_vld;
          r_p_keep  <= i_in_vld && i_in_corner && (i_in_score >= i_min_score) &&
                       (i_in_x >= 10'd1) && (i_in_x <= X_BMAX) &&
                       (i_in_y >= 10'd1) && (i_in_y <= Y_BMAX);
          r_p_last  <= i_in_vld && (i_in_x == X_LAST) && (i_in_y == Y_LAST);
          r_p_x     <= i_in_x;
          r_p_y     <= i_in_y;
          r_p_score <= i_in_score;
        end
      end
    end
  endgenerate

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  logic [15:0]   r_fcnt;
  logic          w_try;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_end;

  assign w_try  = i_ce && r_p_vld && r_p_keep;
  assign w_full = (r_cnt == DEPTH_C);
  // A full FIFO drops the push even if the head pops in the same cycle.
  assign w_push = w_try && !w_full;
  assign w_drop = w_try && w_full;
  assign w_pop  = o_out_vld && i_out_rdy;
  assign w_end  = i_ce && r_p_vld && r_p_last;

  assign o_out_vld   = (r_cnt != '0);
  assign o_out_x     = r_mem[r_rp][EW-1 -: 10];
  assign o_out_y     = r_mem[r_rp][SW +: 10];
  assign o_out_score = r_mem[r_rp][SW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp            <= '0;
      r_rp            <= '0;
      r_cnt           <= '0;
      r_fcnt          <= '0;
      o_frame_done    <= 1'b0;
      o_frame_corners <= '0;
      o_overflow      <= 1'b0;
      o_drop_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {r_p_x, r_p_y, r_p_score};
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      o_frame_done <= w_end;
      if (w_end) begin
        o_frame_corners <= w_push ? f_sat_inc(r_fcnt) : r_fcnt;
        r_fcnt          <= '0;
      end else if (w_push) begin
        r_fcnt <= f_sat_inc(r_fcnt);
      end
      if (w_drop) begin
        o_overflow <= 1'b1;
        o_drop_cnt <= f_sat_inc(o_drop_cnt);
      end
    end
  end

endmodule

// File: doc/fast_nms_stream.md
# fast_nms_stream

Parametrised post-processing stage for the FAST corner pipeline. It consumes the per-pixel corner/score stream produced by the FAST detector top, optionally applies 3x3 non-maximum suppression with line buffers, and filters against a runtime minimum score. Surviving corners are buffered in an output FIFO with a valid/ready handshake, and per-frame corner count and overflow statistics are reported.

## Interface
- COL_NUM, 640, image width in pixels.
- ROW_NUM, 480, image height in pixels.
- SCORE_WIDTH, 13, width of corner score.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4.
- NMS_EN, 1, 1 = 3x3 NMS; 0 = bypass, every qualifying corner is pushed.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  ingress clock enable; low freezes the ingress/NMS pipeline.
- in_vld  in  1  pixel result valid (one per pixel, raster order).
- in_corner  in  1  pixel is a FAST corner.
- in_score  in  SCORE_WIDTH  corner score.
- in_x, in_y  in  10 each  pixel coordinates.
- min_score  in  SCORE_WIDTH  runtime threshold; sampled every cycle.
- out_vld  out  1  FIFO head valid.
- out_rdy  in  1  consumer accepts head.
- out_x, out_y  out  10 each  corner coordinates.
- out_score  out  SCORE_WIDTH  corner score.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is processed.
- frame_corners  out  16  corners pushed in the last completed frame; saturating.
- overflow  out  1  sticky: a corner was dropped because the FIFO was full; cleared only by reset.
- drop_cnt  out  16  dropped corners since reset; saturating at 0xFFFF.

## Operation
- Ingress: an input beat is accepted when ce=1 and in_vld=1. The effective score is in_score when in_corner=1, else 0.
- Line buffers: two COL_NUM x SCORE_WIDTH RAMs, addressed by in_x. On each beat:
  - row y-1 is read from lb1[x] and row y-2 from lb2[x];
  - lb2[x] is written with lb1[x], and lb1[x] with the effective score.
  - The 3-value column shifts into a 3x3 window register.
- Candidate: the window centre is pixel (x-1, y-1). It is evaluated only when 2 <= x <= COL_NUM-1 and 2 <= y <= ROW_NUM-1. Border rows and columns are never emitted.
- NMS keep rule (NMS_EN=1): centre score C > 0, C >= min_score, and:
  - C is strictly greater than the raster-earlier neighbours (-1,-1), (0,-1), (+1,-1), (-1,0);
  - C is >= the raster-later neighbours (+1,0), (-1,+1), (0,+1), (+1,+1).
  - Among equal scores, the raster-earliest pixel wins.
- Bypass (NMS_EN=0): the incoming pixel itself is the candidate. It is kept if in_corner=1 and in_score >= min_score. Border rows and columns are still suppressed. Line buffers are unused.
- Comparisons are unsigned, at full SCORE_WIDTH.
- FIFO push of a kept candidate:
  - If not full: push {x, y, score} and increment the frame counter (saturating).
  - If full: drop the candidate, set overflow, and increment drop_cnt (saturating).
  - Pushing into a full FIFO is dropped even if a pop happens in the same cycle.
- FIFO pop: occurs when out_vld=1 and out_rdy=1. Push and pop in the same cycle with 0 < count < FIFO_DEPTH leaves count unchanged.
- FIFO egress is independent of ce.
- Frame end: the beat at in_x=COL_NUM-1, in_y=ROW_NUM-1 marks the end of the frame.
  - frame_done pulses when that beat's candidate reaches the push stage.
  - frame_corners loads the frame count, including that final push, and the internal count clears.
- out_x, out_y and out_score are the FIFO head; they are don't-care when out_vld=0.

## Timing
- Reset: out_vld=0, out_x=0, out_y=0, out_score=0, frame_done=0, frame_corners=0, overflow=0, drop_cnt=0. FIFO is empty and the window is cleared. Line buffer contents are undefined but never used before they are rewritten: evaluation requires y>=2.
- NMS latency: beat at cycle t (coordinates x, y) produces a push decision for centre (x-1, y-1) at edge t+2. out_vld rises at t+3 if the FIFO was empty.
- Bypass latency: push at edge t+1; out_vld at t+2.
- ce=0: the pipeline registers, window and counters hold, and in-flight candidates are neither lost nor duplicated.
- Reset mid-frame: everything returns to reset values. Results resume correctly from the next frame starting at (0,0).
- Back-to-back beats are supported at one pixel per cycle. Gaps (in_vld=0) are allowed anywhere.

## Test plan
- Single corner, NMS_EN=1, min_score=0:
  - Stimulus: score 50 at (10,10), all other pixels 0.
  - Required: exactly one output (10,10,50), 2 cycles after the (11,11) beat is pushed; frame_corners=1 at frame_done.
- Plateau tie:
  - Stimulus: equal score 30 at (10,10) and (11,10).
  - Required: only (10,10) is emitted. Variant: (11,10)=31 -> only (11,10) is emitted.
- min_score filter:
  - Stimulus: isolated corners with scores 5, 20 and 40; min_score=20.
  - Required: outputs are the 20 and 40 corners only; frame_corners=2.
- Backpressure overflow, FIFO_DEPTH=4:
  - Stimulus: out_rdy=0 for the whole frame; 6 isolated corners.
  - Required: 4 entries held; overflow=1; drop_cnt=2. On raising out_rdy, 4 pops in raster order, then out_vld=0.
- Bypass, NMS_EN=0:
  - Stimulus: adjacent corners at (10,10)=30 and (11,10)=30, plus a corner on row 0.
  - Required: both interior corners are emitted 1 cycle after their beats; the row-0 corner is suppressed.
- Reset and ce:
  - Stimulus: hold ce=0 for 5 cycles during a row containing a corner.
  - Required: output is identical to the ce=1 run.
  - Stimulus: assert rst mid-frame.
  - Required: all outputs are 0 immediately; the next full frame gives the correct results.
